bbf_pipe_alu: RTL

Simulation-only, pipelined, multi-lane double-precision ALU built on Verilog real-number system functions (`$bitstoreal`, `$realtobits`, `$itor`, `$rtoi`). It replaces per-operation combinational float black boxes with one opcode-selected unit. The unit has a valid/ready handshake, configurable latency and a per-transaction tag. It sits behind the DspReal/BlackBox float type in testbench and emulation flows, where a realistic pipeline depth and backpressure are needed. It is not synthesizable.

---
 rtl/bbf_pkg.sv | 44 ++++
 rtl/bbf_lane_op.sv | 81 ++++++++
 rtl/bbf_pipe_alu.sv | 89 ++++++++
 3 files changed

// File: rtl/bbf_pkg.sv
// Shared types and constants for the bbf real-number ALU.
// Optional flag generation is controlled by BBF_PIPE_FLAGS_EN.
package bbf_pkg;

    localparam int unsigned BBF_W  = 64;
    localparam int unsigned FLAG_W = 4;

    localparam int unsigned FLAG_INVALID = 3;
    localparam int unsigned FLAG_DIV0    = 2;
    localparam int unsigned FLAG_OVF     = 1;
    localparam int unsigned FLAG_INEXACT = 0;

    localparam logic [BBF_W-1:0] INT64_MAX = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [BBF_W-1:0] INT64_MIN = 64'h8000_0000_0000_0000;

    typedef enum logic [3:0] {
        OP_ADD      = 4'd0,
        OP_SUB      = 4'd1,
        OP_MUL      = 4'd2,
        OP_DIV      = 4'd3,
        OP_LT       = 4'd4,
        OP_LE       = 4'd5,
        OP_EQ       = 4'd6,
        OP_MIN      = 4'd7,
        OP_MAX      = 4'd8,
        OP_FROM_INT = 4'd9,
        OP_TO_INT   = 4'd10,
        OP_NEG      = 4'd11,
        OP_ABS      = 4'd12
    } bbf_op_e;

    function automatic logic is_nan(input logic [BBF_W-1:0] v);
        return (&v[62:52]) && (|v[51:0]);
    endfunction

    function automatic logic is_inf(input logic [BBF_W-1:0] v);
        return (&v[62:52]) && !(|v[51:0]);
    endfunction

    function automatic logic is_zero(input logic [BBF_W-1:0] v);
        return ~|v[62:0];
    endfunction

endpackage

// File: rtl/bbf_lane_op.sv
// Combinational single-lane double-precision operation (op, a, b -> result, flags).
// Flag logic exists only when BBF_PIPE_FLAGS_EN is defined; otherwise flags_o is 0.
module bbf_lane_op
    import bbf_pkg::*;
(
    input  logic [3:0]        op_i,
    input  logic [BBF_W-1:0]  a_i,
    input  logic [BBF_W-1:0]  b_i,
    output logic [BBF_W-1:0]  res_o,
    output logic [FLAG_W-1:0] flags_o
);

    localparam real TWO63 = 9223372036854775808.0;

    real  a_r;
    real  b_r;
    real  t_r;
    logic a_nan;
    logic b_nan;
    logic to_int_sat;

    assign a_nan      = is_nan(a_i);
    assign b_nan      = is_nan(b_i);
    assign to_int_sat = !a_nan && ((a_r >= TWO63) || (a_r < -TWO63));

    always_comb begin
        a_r = $bitstoreal(a_i);
        b_r = $bitstoreal(b_i);
        // truncation toward zero, exact once the value is integral
        t_r = (a_r < 0.0) ? $ceil(a_r) : $floor(a_r);
    end

    always_comb begin
        res_o = '0;
        case (op_i)
            OP_ADD:      res_o = $realtobits(a_r + b_r);
            OP_SUB:      res_o = $realtobits(a_r - b_r);
            OP_MUL:      res_o = $realtobits(a_r * b_r);
            OP_DIV:      res_o = $realtobits(a_r / b_r);
            OP_LT:       res_o = {63'b0, (a_r <  b_r)};
            OP_LE:       res_o = {63'b0, (a_r <= b_r)};
            OP_EQ:       res_o = {63'b0, (a_r == b_r)};
            OP_MIN:      res_o = a_nan ? b_i : (b_nan ? a_i : ((b_r < a_r) ? b_i : a_i));
            OP_MAX:      res_o = a_nan ? b_i : (b_nan ? a_i : ((b_r > a_r) ? b_i : a_i));
            OP_FROM_INT: res_o = $realtobits(real'($signed(a_i)));
            OP_TO_INT: begin
                if (a_nan)              res_o = '0;
                else if (a_r >= TWO63)  res_o = INT64_MAX;
                else if (a_r < -TWO63)  res_o = INT64_MIN;
                else                    res_o = longint'(t_r);
            end
            OP_NEG:      res_o = {~a_i[63], a_i[62:0]};
            OP_ABS:      res_o = {1'b0, a_i[62:0]};
            default:     res_o = '0;
        endcase
    end

`ifdef BBF_PIPE_FLAGS_EN
    always_comb begin
        flags_o = '0;
        case (op_i)
            OP_ADD, OP_SUB, OP_MUL, OP_DIV:
                flags_o[FLAG_INVALID] = is_nan(res_o) && !a_nan && !b_nan;
            OP_LT, OP_LE, OP_EQ:
                flags_o[FLAG_INVALID] = a_nan || b_nan;
            OP_TO_INT: begin
                flags_o[FLAG_OVF]     = to_int_sat;
                flags_o[FLAG_INEXACT] = !a_nan && !to_int_sat && (t_r != a_r);
            end
            OP_MIN, OP_MAX, OP_FROM_INT, OP_NEG, OP_ABS: ;
            default:
                flags_o[FLAG_INVALID] = 1'b1;
        endcase
        if (op_i == OP_DIV && is_zero(b_i) && !is_zero(a_i) && !a_nan && !is_inf(a_i))
            flags_o[FLAG_DIV0] = 1'b1;
    end
`else
    assign flags_o = '0;
`endif

endmodule

// File: rtl/bbf_pipe_alu.sv
// Multi-lane pipelined real-number ALU: lane compute in stage 0, LATENCY stall-able stages.
// BBF_PIPE_FLAGS_EN enables per-lane flag generation and flag pipeline registers.
module bbf_pipe_alu
    import bbf_pkg::*;
#(
    parameter int unsigned LANES   = 1,
    parameter int unsigned LATENCY = 3,
    parameter int unsigned TAG_W   = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [3:0]                in_op,
    input  logic [BBF_W*LANES-1:0]    in_a,
    input  logic [BBF_W*LANES-1:0]    in_b,
    input  logic [TAG_W-1:0]          in_tag,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [BBF_W*LANES-1:0]    out_data,
    output logic [TAG_W-1:0]          out_tag,
    output logic [FLAG_W*LANES-1:0]   out_flags
);

    logic [BBF_W*LANES-1:0]  data_d;
    logic [FLAG_W*LANES-1:0] flags_d;
    logic                    advance;

    logic [LATENCY-1:0]                        valid_q;
    logic [LATENCY-1:0][BBF_W*LANES-1:0]       data_q;
    logic [LATENCY-1:0][TAG_W-1:0]             tag_q;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        bbf_lane_op u_lane (
            .op_i    (in_op),
            .a_i     (in_a[BBF_W*i +: BBF_W]),
            .b_i     (in_b[BBF_W*i +: BBF_W]),
            .res_o   (data_d[BBF_W*i +: BBF_W]),
            .flags_o (flags_d[FLAG_W*i +: FLAG_W])
        );
    end

    // one global stall: every stage holds whenever the head is blocked
    assign advance  = !valid_q[LATENCY-1] || out_ready;
    assign in_ready = advance;

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '0;
            data_q  <= '0;
            tag_q   <= '0;
        end else if (advance) begin
            valid_q[0] <= in_valid;
            data_q[0]  <= data_d;
            tag_q[0]   <= in_tag;
            for (int unsigned k = 1; k < LATENCY; k++) begin
                valid_q[k] <= valid_q[k-1];
                data_q[k]  <= data_q[k-1];
                tag_q[k]   <= tag_q[k-1];
            end
        end
    end

    assign out_valid = valid_q[LATENCY-1];
    assign out_data  = data_q[LATENCY-1];
    assign out_tag   = tag_q[LATENCY-1];

`ifdef BBF_PIPE_FLAGS_EN
    logic [LATENCY-1:0][FLAG_W*LANES-1:0] flags_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            flags_q <= '0;
        end else if (advance) begin
            flags_q[0] <= flags_d;
            for (int unsigned k = 1; k < LATENCY; k++) begin
                flags_q[k] <= flags_q[k-1];
            end
        end
    end

    assign out_flags = flags_q[LATENCY-1];
`else
    logic unused_flags;
    assign unused_flags = ^flags_d;
    assign out_flags    = '0;
`endif

endmodule
